// File: rtl/dtree_control_mc_if.sv
// rtl/dtree_control_mc_if.sv - request/result, datapath command and node-config bundle for dtree_control_mc
// DTREE_CFG_READBACK_EN adds cfg_re/cfg_rdata.
interface dtree_control_mc_if #(
    parameter int FEATURES        = 3,
    parameter int COEFF_BIT_DEPTH = 4,
    parameter int BIAS_BIT_DEPTH  = 10,
    parameter int TREE_DEPTH      = 3,
    parameter int CHANNEL_COUNT   = 16
);
    localparam int MAX_NODES = (1 << TREE_DEPTH) - 1;
    localparam int WORD_W    = 2 + FEATURES + (FEATURES - 1) * COEFF_BIT_DEPTH + BIAS_BIT_DEPTH;
    localparam int CH_W      = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
    localparam int FS_W      = (FEATURES > 1) ? $clog2(FEATURES) : 1;
    localparam int LVL_W     = (TREE_DEPTH > 1) ? $clog2(TREE_DEPTH) : 1;
    localparam int ADDR_W    = $clog2(CHANNEL_COUNT * MAX_NODES);

    logic                       in_valid;
    logic [CH_W-1:0]            in_channel;
    logic                       in_ready;
    logic                       load_bias;
    logic                       mult;
    logic                       add;
    logic                       is_one;
    logic [FS_W-1:0]            feature_sel;
    logic [COEFF_BIT_DEPTH-1:0] coeff;
    logic [BIAS_BIT_DEPTH-1:0]  bias;
    logic                       dir_valid;
    logic                       child_direction;
    logic                       out_valid;
    logic                       out_ready;
    logic [CH_W-1:0]            out_channel;
    logic [LVL_W-1:0]           out_level;
    logic [TREE_DEPTH-1:0]      out_path;
    logic                       out_overflow;
    logic                       cfg_we;
    logic [ADDR_W-1:0]          cfg_addr;
    logic [WORD_W-1:0]          cfg_wdata;
`ifdef DTREE_CFG_READBACK_EN
    logic                       cfg_re;
    logic [WORD_W-1:0]          cfg_rdata;
`endif

    modport slave (
`ifdef DTREE_CFG_READBACK_EN
        input  cfg_re,
        output cfg_rdata,
`endif
        input  in_valid, in_channel, dir_valid, child_direction, out_ready,
        input  cfg_we, cfg_addr, cfg_wdata,
        output in_ready, load_bias, mult, add, is_one, feature_sel, coeff, bias,
        output out_valid, out_channel, out_level, out_path, out_overflow
    );

    modport master (
`ifdef DTREE_CFG_READBACK_EN
        output cfg_re,
        input  cfg_rdata,
`endif
        output in_valid, in_channel, dir_valid, child_direction, out_ready,
        output cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, load_bias, mult, add, is_one, feature_sel, coeff, bias,
        input  out_valid, out_channel, out_level, out_path, out_overflow
    );
endinterface

// File: rtl/dtree_control_mc.sv
// rtl/dtree_control_mc.sv - multi-channel heap-order decision-tree traversal controller
// DTREE_CFG_READBACK_EN enables config readback of node memory while idle.
module dtree_control_mc #(
    parameter int FEATURES        = 3,
    parameter int COEFF_BIT_DEPTH = 4,
    parameter int BIAS_BIT_DEPTH  = 10,
    parameter int TREE_DEPTH      = 3,
    parameter int CHANNEL_COUNT   = 16
) (
    input  logic              clk,
    input  logic              reset,
    dtree_control_mc_if.slave bus
);
    localparam int MAX_NODES = (1 << TREE_DEPTH) - 1;
    localparam int DEPTH     = CHANNEL_COUNT * MAX_NODES;
    localparam int WORD_W    = 2 + FEATURES + (FEATURES - 1) * COEFF_BIT_DEPTH + BIAS_BIT_DEPTH;
    localparam int CH_W      = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
    localparam int FS_W      = (FEATURES > 1) ? $clog2(FEATURES) : 1;
    localparam int LVL_W     = (TREE_DEPTH > 1) ? $clog2(TREE_DEPTH) : 1;
    localparam int NODE_W    = (TREE_DEPTH > 1) ? $clog2(MAX_NODES) : 1;
    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int CF_W      = (FEATURES - 1) * COEFF_BIT_DEPTH;
    localparam int OP_LSB    = BIAS_BIT_DEPTH + CF_W;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EVAL, S_WAIT_DIR, S_RESULT} state_t;

    state_t                     state_q, state_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [NODE_W-1:0]          node_q, node_d;
    logic [LVL_W-1:0]           level_q, level_d;
    logic [TREE_DEPTH-1:0]      path_q, path_d;
    logic                       ovf_q, ovf_d;
    logic [FS_W-1:0]            k_q, k_d;
    logic [FS_W-1:0]            j_q, j_d;
    logic [WORD_W-1:0]          word_q, word_d;

    logic [WORD_W-1:0]          mem [DEPTH];

    logic [ADDR_W-1:0]          fetch_addr;
    logic                       cfg_addr_ok;
    logic                       req_ch_bad;
    logic                       accept;
    logic                       eval_last;
    logic                       child_valid;
    logic                       descend;
    logic [1:0]                 flags;
    logic [FEATURES-1:0]        one_pos;
    logic                       is_one_c;
    logic                       mult_c;
    logic [COEFF_BIT_DEPTH-1:0] coeff_c;

    // Range checks only exist when the field width can express out-of-range values.
    if (CHANNEL_COUNT < (1 << CH_W)) begin : g_ch_chk
        assign req_ch_bad = (bus.in_channel >= CH_W'(CHANNEL_COUNT));
    end else begin : g_ch_full
        assign req_ch_bad = 1'b0;
    end

    if (DEPTH < (1 << ADDR_W)) begin : g_addr_chk
        assign cfg_addr_ok = (bus.cfg_addr < ADDR_W'(DEPTH));
    end else begin : g_addr_full
        assign cfg_addr_ok = 1'b1;
    end

    assign fetch_addr  = ADDR_W'(32'(ch_q) * MAX_NODES + 32'(node_q));
    assign accept      = bus.in_valid && bus.in_ready;
    assign eval_last   = (k_q == FS_W'(FEATURES - 1));
    assign flags       = word_q[WORD_W-1 -: 2];
    assign one_pos     = word_q[OP_LSB +: FEATURES];
    assign child_valid = bus.child_direction ? flags[0] : flags[1];
    assign descend     = child_valid && (32'(level_q) < TREE_DEPTH - 1);
    assign bus.in_ready = reset && (state_q == S_IDLE);

    // Node memory is deliberately not reset; the registered fetch makes reads read-first.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && cfg_addr_ok) begin
            mem[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    // Coefficient slot j is the j-th non-implicit-one feature of the node.
    always_comb begin
        is_one_c = one_pos[FS_W'(FEATURES - 1) - k_q];
        coeff_c  = '0;
        if (!is_one_c) begin
            for (int i = 0; i < FEATURES - 1; i++) begin
                if (32'(j_q) == i) begin
                    coeff_c = word_q[BIAS_BIT_DEPTH + CF_W - 1 - i * COEFF_BIT_DEPTH -: COEFF_BIT_DEPTH];
                end
            end
        end
        mult_c = !is_one_c && (coeff_c != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            node_q  <= '0;
            level_q <= '0;
            path_q  <= '0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
            j_q     <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            node_q  <= node_d;
            level_q <= level_d;
            path_q  <= path_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
            j_q     <= j_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (accept) state_d = req_ch_bad ? S_RESULT : S_FETCH;
            S_FETCH:    state_d = S_EVAL;
            S_EVAL:     if (eval_last) state_d = S_WAIT_DIR;
            S_WAIT_DIR: if (bus.dir_valid) state_d = descend ? S_FETCH : S_RESULT;
            S_RESULT:   if (bus.out_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ch_d    = ch_q;
        node_d  = node_q;
        level_d = level_q;
        path_d  = path_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        j_d     = j_q;
        word_d  = word_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ch_d    = bus.in_channel;
                    node_d  = '0;
                    level_d = '0;
                    path_d  = '0;
                    ovf_d   = req_ch_bad;
                end
            end
            S_FETCH: begin
                word_d = mem[fetch_addr];
                k_d    = '0;
                j_d    = '0;
            end
            S_EVAL: begin
                k_d = k_q + 1'b1;
                if (!is_one_c) j_d = j_q + 1'b1;
            end
            S_WAIT_DIR: begin
                if (bus.dir_valid) begin
                    path_d = path_q | (TREE_DEPTH'(bus.child_direction) << level_q);
                    if (descend) begin
                        node_d  = NODE_W'(2 * 32'(node_q) + 1 + 32'(bus.child_direction));
                        level_d = level_q + 1'b1;
                    end else begin
                        ovf_d = child_valid;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.load_bias    = 1'b0;
        bus.mult         = 1'b0;
        bus.add          = 1'b0;
        bus.is_one       = 1'b0;
        bus.feature_sel  = '0;
        bus.coeff        = '0;
        bus.bias         = '0;
        bus.out_valid    = 1'b0;
        bus.out_channel  = '0;
        bus.out_level    = '0;
        bus.out_path     = '0;
        bus.out_overflow = 1'b0;
        if (state_q == S_EVAL) begin
            bus.load_bias   = (k_q == '0);
            bus.mult        = mult_c;
            bus.add         = is_one_c || mult_c;
            bus.is_one      = is_one_c;
            bus.feature_sel = k_q;
            bus.coeff       = coeff_c;
            bus.bias        = word_q[BIAS_BIT_DEPTH-1:0];
        end
        if (state_q == S_RESULT) begin
            bus.out_valid    = 1'b1;
            bus.out_channel  = ch_q;
            bus.out_level    = level_q;
            bus.out_path     = path_q;
            bus.out_overflow = ovf_q;
        end
    end

`ifdef DTREE_CFG_READBACK_EN
    logic [WORD_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if ((state_q == S_IDLE) && bus.cfg_re) begin
            rdata_d = cfg_addr_ok ? mem[bus.cfg_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign bus.cfg_rdata = rdata_q;
`endif
endmodule

// File: tb/tb_dtree_control_mc.sv
// tb/tb_dtree_control_mc.sv - scoreboard bench for dtree_control_mc against a tree-walk reference model
module tb_dtree_control_mc;
    localparam int F = 3, C = 4, B = 10, TD = 3, CH = 16;
    localparam int MN = 7, DEPTH = CH * MN, WORD_W = 2 + F + (F - 1) * C + B;

    typedef logic [21:0] cmd_t;   // {load_bias, mult, add, is_one, feature_sel[1:0], coeff[3:0], bias[9:0]}
    typedef logic [9:0]  res_t;   // {channel[3:0], level[1:0], path[2:0], overflow}

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dtree_control_mc_if #(.FEATURES(F), .COEFF_BIT_DEPTH(C), .BIAS_BIT_DEPTH(B),
                          .TREE_DEPTH(TD), .CHANNEL_COUNT(CH)) bus ();

    dtree_control_mc #(.FEATURES(F), .COEFF_BIT_DEPTH(C), .BIAS_BIT_DEPTH(B),
                       .TREE_DEPTH(TD), .CHANNEL_COUNT(CH)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    logic [WORD_W-1:0] ref_mem [DEPTH];
    cmd_t cmd_q[$];
    res_t res_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   evals_seen = 0;
    int   req_base = 0;
    logic [TD-1:0] cur_dirs = '0;
    bit   hold_out = 1'b0;
    bit   force_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each node gives FEATURES ops; feature k is pass-through when its one_pos bit is set,
    // otherwise it consumes the next stored coefficient slot in order.
    task automatic model_node(input logic [WORD_W-1:0] w);
        logic [2:0] onep;
        logic [3:0] slot [2];
        logic [3:0] cf;
        logic       io, m;
        int         used;
        onep    = w[20:18];
        slot[0] = w[17:14];
        slot[1] = w[13:10];
        used    = 0;
        for (int k = 0; k < F; k++) begin
            io = onep[2'(F - 1 - k)];
            cf = 4'd0;
            if (!io) begin
                if (used < F - 1) cf = slot[used];
                used++;
            end
            m = !io && (cf != 4'd0);
            cmd_q.push_back({(k == 0), m, io || m, io, 2'(k), cf, w[9:0]});
        end
    endtask

    task automatic model_req(input int ch, input logic [TD-1:0] dirs);
        int            nd;
        logic [1:0]    lv, fl;
        logic [TD-1:0] path;
        logic          d, cv, ovf;
        bit            done;
        nd = 0; lv = 2'd0; path = '0; ovf = 1'b0; done = 1'b0;
        while (!done) begin
            model_node(ref_mem[ch * MN + nd]);
            fl = ref_mem[ch * MN + nd][WORD_W-1 -: 2];
            d  = dirs[lv];
            path[lv] = d;
            cv = (fl == 2'b11) || (fl == 2'b10 && !d) || (fl == 2'b01 && d);
            if (cv && lv < 2'(TD - 1)) begin
                nd = 2 * nd + 1 + int'(d);
                lv = lv + 2'd1;
            end else begin
                ovf  = cv;
                done = 1'b1;
            end
        end
        res_q.push_back({4'(ch), lv, path, ovf});
    endtask

    task automatic cfg_write(input int addr, input logic [WORD_W-1:0] w);
        @(negedge clk);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 7'(addr);
        bus.cfg_wdata = w;
        if (addr < DEPTH) ref_mem[addr] = w;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic issue_req(input int ch, input logic [TD-1:0] dirs);
        int t;
        model_req(ch, dirs);
        @(negedge clk);
        req_base       = evals_seen;
        cur_dirs       = dirs;
        bus.in_valid   = 1'b1;
        bus.in_channel = 4'(ch);
        t = 0;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("accept_in_time", (t < 100), 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((cmd_q.size() != 0 || res_q.size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("done_in_time", (t < 400), 1'b1);
        if (t >= 400) begin
            rst_n = 1'b0;
            @(negedge clk);
            cmd_q.delete();
            res_q.delete();
            rst_n = 1'b1;
        end
    endtask

    task automatic wait_first_eval();
        int t;
        t = 0;
        while (evals_seen == req_base && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("eval_started", (t < 100), 1'b1);
    endtask

    initial begin : monitor
        cmd_t got_c;
        res_t got_r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.load_bias || bus.feature_sel != 2'd0) begin
                    if (bus.load_bias) evals_seen++;
                    got_c = {bus.load_bias, bus.mult, bus.add, bus.is_one, bus.feature_sel, bus.coeff, bus.bias};
                    if (cmd_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL cmd_unexpected: got %h required none", got_c);
                    end else begin
                        check("cmd", got_c, cmd_q.pop_front());
                    end
                end
                if (bus.out_valid) begin
                    got_r = {bus.out_channel, bus.out_level, bus.out_path, bus.out_overflow};
                    check("in_ready_low_in_result", bus.in_ready, 1'b0);
                    if (res_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL result_unexpected: got %h required none", got_r);
                    end else begin
                        check("result", got_r, res_q[0]);
                        if (bus.out_ready) void'(res_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : responder
        int idx;
        bus.dir_valid       = 1'b0;
        bus.child_direction = 1'b0;
        bus.out_ready       = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            idx = evals_seen - req_base - 1;
            if (idx < 0) idx = 0;
            if (idx > TD - 1) idx = TD - 1;
            bus.dir_valid       = ($urandom_range(0, 2) == 0);
            bus.child_direction = cur_dirs[idx[1:0]];
            bus.out_ready       = hold_out ? 1'b0 : (force_ready ? 1'b1 : 1'($urandom_range(0, 1)));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [WORD_W-1:0] w;
        bus.in_valid   = 1'b0;
        bus.in_channel = '0;
        bus.cfg_we     = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_wdata  = '0;
`ifdef DTREE_CFG_READBACK_EN
        bus.cfg_re     = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1'b1);
        check("idle_out_valid", bus.out_valid, 1'b0);
        check("idle_cmds", {bus.load_bias, bus.mult, bus.add}, 3'b000);

        for (int a = 0; a < DEPTH; a++) cfg_write(a, WORD_W'($urandom));
        cfg_write(DEPTH + $urandom_range(0, 127 - DEPTH), WORD_W'($urandom));

        // Single node: implicit one on feature 0, coefficients 3 and 5.
        cfg_write(2 * MN, {2'b00, 3'b100, 4'd3, 4'd5, 10'd7});
        issue_req(2, 3'b001);
        wait_done();

        // Path 0 -> 2 -> 5.
        cfg_write(0 * MN + 0, {2'b11, 21'($urandom)});
        cfg_write(0 * MN + 2, {2'b11, 21'($urandom)});
        cfg_write(0 * MN + 5, {2'b00, 21'($urandom)});
        issue_req(0, 3'b101);
        wait_done();

        // Every node wants a child: descends past the last level.
        for (int n = 0; n < MN; n++) cfg_write(3 * MN + n, {2'b11, 21'($urandom)});
        issue_req(3, 3'b000);
        wait_done();

        // Backpressure held for 10 cycles.
        hold_out = 1'b1;
        issue_req(5, 3'($urandom));
        begin
            int t;
            t = 0;
            while (!bus.out_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("result_reached", (t < 200), 1'b1);
        end
        repeat (10) @(negedge clk);
        check("hold_in_ready", bus.in_ready, 1'b0);
        check("hold_out_valid", bus.out_valid, 1'b1);
        hold_out    = 1'b0;
        force_ready = 1'b1;
        wait_done();
        @(negedge clk);
        check("idle_after_result", bus.in_ready, 1'b1);
        force_ready = 1'b0;
        issue_req(6, 3'($urandom));
        wait_done();

        // Rewrite the node being evaluated: current walk keeps the old bias.
        cfg_write(1 * MN, {2'b00, 3'b010, 4'd2, 4'd6, 10'd7});
        issue_req(1, 3'($urandom));
        wait_first_eval();
        cfg_write(1 * MN, {2'b00, 3'b010, 4'd2, 4'd6, 10'd9});
        wait_done();
        issue_req(1, 3'($urandom));
        wait_done();

        // Reset during EVAL abandons the walk.
        issue_req(4, 3'($urandom));
        wait_first_eval();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_cmds", {bus.load_bias, bus.mult, bus.add, bus.is_one}, 4'b0000);
        check("rst_mid_sel_bias", {bus.feature_sel, bus.coeff, bus.bias}, 16'h0000);
        check("rst_mid_out_valid", bus.out_valid, 1'b0);
        check("rst_mid_in_ready", bus.in_ready, 1'b0);
        cmd_q.delete();
        res_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_idle", bus.in_ready, 1'b1);
        repeat (20) @(negedge clk);
        check("rst_mid_no_result", bus.out_valid, 1'b0);

        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 2) == 0) cfg_write($urandom_range(0, 127), WORD_W'($urandom));
            w = WORD_W'($urandom);
            if (r % 4 == 0) cfg_write($urandom_range(0, CH - 1) * MN, {2'b11, w[20:0]});
            issue_req($urandom_range(0, CH - 1), 3'($urandom));
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dtree_control_mc.md
Name: dtree_control_mc

Overview:
- Multi-channel, depth-parametrised decision-tree traversal controller for the spike-sorting pipeline.
- Accepts one spike-evaluation request per channel and walks that channel's tree stored in heap order.
- For each node it issues per-feature multiply/add commands to the linear-classifier datapath and consumes the datapath's sign bit.
- Emits the leaf level and path with valid/ready backpressure. Node memory is programmable at run time through a config write port.

Parameters:
- FEATURES, 3, features per spike; one datapath op slot per feature.
- COEFF_BIT_DEPTH, 4, stored coefficient width.
- BIAS_BIT_DEPTH, 10, stored bias width.
- TREE_DEPTH, 3, maximum node levels; MAX_NODES = 2^TREE_DEPTH-1 per channel.
- CHANNEL_COUNT, 16, number of independent trees.
- WORD_W (derived), 2+FEATURES+(FEATURES-1)*COEFF_BIT_DEPTH+BIAS_BIT_DEPTH, node word width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  evaluation request.
- in_channel  in  clog2(CHANNEL_COUNT)  channel of request.
- in_ready  out  1  controller idle, can accept.
- load_bias  out  1  datapath: load bias into accumulator.
- mult  out  1  datapath: multiply selected feature by coeff.
- add  out  1  datapath: accumulate this cycle's term.
- is_one  out  1  coefficient is implicit 1 (feature passed through).
- feature_sel  out  clog2(FEATURES)  feature index for this op.
- coeff  out  COEFF_BIT_DEPTH  current coefficient.
- bias  out  BIAS_BIT_DEPTH  current node bias.
- dir_valid  in  1  datapath sign result valid.
- child_direction  in  1  sign result: 0 left, 1 right.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_channel  out  clog2(CHANNEL_COUNT)  channel of result.
- out_level  out  clog2(TREE_DEPTH)  level of last evaluated node.
- out_path  out  TREE_DEPTH  decision bit per level; bits above out_level are 0.
- out_overflow  out  1  tree wanted to descend past TREE_DEPTH-1.
- cfg_we  in  1  node memory write strobe.
- cfg_addr  in  clog2(CHANNEL_COUNT*MAX_NODES)  write address = ch*MAX_NODES+node.
- cfg_wdata  in  WORD_W  node word.

Behaviour:
- Node word, MSB first: child_flags[1:0], one_pos[FEATURES-1:0], coeff slots 0..FEATURES-2, bias.
- Reset: all outputs 0 except in_ready=0 while reset is asserted, then 1 in IDLE. FSM goes to IDLE; path, level and channel registers clear. Memory contents are not cleared.
- Reset mid-traversal abandons the traversal; no result is emitted.
- FSM states: IDLE, FETCH, EVAL, WAIT_DIR, RESULT.
- IDLE: in_ready=1. A request is accepted when in_valid&in_ready: latch in_channel, node=0, level=0, path=0, go to FETCH.
- FETCH: one-cycle synchronous memory read of ch*MAX_NODES+node, then EVAL.
- EVAL: exactly FEATURES cycles, k=0..FEATURES-1.
  - feature_sel=k; is_one=one_pos[FEATURES-1-k].
  - coeff = slot j, where j counts prior non-one features of this node; coeff=0 when is_one.
  - load_bias=(k==0); mult=~is_one&(coeff!=0); add=is_one|mult.
  - bias is held valid throughout EVAL. Then go to WAIT_DIR.
- WAIT_DIR: all command outputs 0. Wait until dir_valid (any number of cycles). On that edge: path[level]=child_direction.
  - child_valid from flags: 00 none; 10 dir==0; 01 dir==1; 11 always.
  - If child_valid and level<TREE_DEPTH-1: node=2*node+1+dir, level+1, go to FETCH.
  - If child_valid and level==TREE_DEPTH-1: out_overflow=1, go to RESULT.
  - Else: go to RESULT.
- RESULT: out_valid=1. out_* stay stable until out_ready. When out_valid&out_ready, return to IDLE. in_ready stays 0 until IDLE.
- dir_valid outside WAIT_DIR is ignored.
- Minimum latency per level: 1+FEATURES+1 cycles.
- cfg writes are accepted in any state. A write to the address being read in the same cycle returns old data (read-first). Data written lands in the next FETCH.
- cfg_addr >= CHANNEL_COUNT*MAX_NODES: write ignored.
- in_channel >= CHANNEL_COUNT: request accepted, immediate RESULT with level=0, path=0, out_overflow=1.

Optional Feature:
- DTREE_CFG_READBACK_EN defined: adds ports cfg_re (in, 1) and cfg_rdata (out, WORD_W).
  - A read issued in IDLE returns the word one cycle later.
  - A read issued outside IDLE is ignored and cfg_rdata holds its value.
  - cfg_rdata resets to 0.
- Undefined: ports absent; memory is write-only from config.

Test Plan:
- Reset release, no requests -> in_ready=1; out_valid, load_bias, mult and add all 0. Assert reset mid-EVAL -> outputs 0 next edge, FSM in IDLE.
- Ch 2, node 0 flags=00, one_pos=100, coeffs 3,5, bias 7; dir=1 -> EVAL ops:
  - k0: load_bias=1, is_one=1, add=1.
  - k1: mult=1, coeff=3.
  - k2: mult=1, coeff=5.
  - Result: channel=2, level=0, path=001, overflow=0.
- Ch 0, flags=11 at nodes 0 and 2, flags=00 at node 5; dirs 1,0,1 -> nodes visited 0,2,5; level=2, path=101.
- TREE_DEPTH=3, all nodes flags=11, dirs 0,0,0 -> level=2, path=000, out_overflow=1.
- Result with out_ready held 0 for 10 cycles -> out_* stable, in_ready=0. Then out_ready=1 -> IDLE next cycle, new request accepted.
- Reprogram ch 1 node 0 bias from 7 to 9 during an active traversal of ch 1 -> current node keeps 7; the next request on ch 1 sees bias=9.
